// File: rtl/shift_reg_piso_tx_if.sv
// Handshake and serial-output bundle for shift_reg_piso_tx.
// The master side supplies words; the slave (transmitter) drives the serial outputs.
interface shift_reg_piso_tx_if #(
  parameter int N = 8
);
  logic         load;
  logic [N-1:0] d;
  logic         msb_first;
  logic         ready;
  logic         busy;
  logic         sd;
  logic         sd_valid;
  logic         done;

  modport master (
    output load, d, msb_first,
    input  ready, busy, sd, sd_valid, done
  );

  modport slave (
    input  load, d, msb_first,
    output ready, busy, sd, sd_valid, done
  );
endinterface

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in/serial-out frame transmitter: start, N data bits, [parity], stop.
// Optional even-parity bit is enabled by defining SHIFT_REG_PISO_TX_PARITY_EN.
module shift_reg_piso_tx #(
  parameter int N       = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_syn_clr,
  shift_reg_piso_tx_if.slave    bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(N);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'((CLK_DIV > 1) ? (CLK_DIV - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic             DONE_ON_ENTRY = (CLK_DIV == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SHIFT_REG_PISO_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_sr;
  logic             r_msb;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sd;
  logic             r_sd_valid;
  logic             r_done;
`ifdef SHIFT_REG_PISO_TX_PARITY_EN
  logic             r_par;
`endif

  logic             w_tick;
  logic             w_end_bit;
  logic [N-1:0]     w_sr_shift;

  // The bit to send next always sits at the outgoing end of the shift register.
  assign w_tick     = (r_div == DIV_LAST);
  assign w_end_bit  = r_msb ? r_sr[N-1] : r_sr[0];
  assign w_sr_shift = r_msb ? {r_sr[N-2:0], 1'b0} : {1'b0, r_sr[N-1:1]};

  // Frame sequencer with registered serial outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_msb      <= 1'b0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_sd       <= 1'b1;
      r_sd_valid <= 1'b0;
      r_done     <= 1'b0;
`ifdef SHIFT_REG_PISO_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else if (i_syn_clr) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_msb      <= 1'b0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_sd       <= 1'b1;
      r_sd_valid <= 1'b0;
      r_done     <= 1'b0;
`ifdef SHIFT_REG_PISO_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_sr    <= bus.d;
            r_msb   <= bus.msb_first;
`ifdef SHIFT_REG_PISO_TX_PARITY_EN
            r_par   <= ^bus.d;
`endif
            r_state <= S_START;
            r_sd    <= 1'b0;
            r_div   <= '0;
            r_cnt   <= '0;
          end else begin
            r_sd       <= 1'b1;
            r_sd_valid <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_div      <= '0;
            r_state    <= S_DATA;
            r_sd       <= w_end_bit;
            r_sd_valid <= 1'b1;
            r_sr       <= w_sr_shift;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_div <= '0;
            if (r_cnt == CNT_LAST) begin
              r_sd_valid <= 1'b0;
`ifdef SHIFT_REG_PISO_TX_PARITY_EN
              r_state    <= S_PARITY;
              r_sd       <= r_par;
`else
              r_state    <= S_STOP;
              r_sd       <= 1'b1;
              r_done     <= DONE_ON_ENTRY;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_sd  <= w_end_bit;
              r_sr  <= w_sr_shift;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
`ifdef SHIFT_REG_PISO_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_div   <= '0;
            r_state <= S_STOP;
            r_sd    <= 1'b1;
            r_done  <= DONE_ON_ENTRY;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // done is raised one edge early so it lands on the final stop cycle.
          if (w_tick) begin
            r_div   <= '0;
            r_state <= S_IDLE;
            r_sd    <= 1'b1;
          end else begin
            r_div  <= r_div + 1'b1;
            r_done <= (r_div == DIV_PRE);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_div      <= '0;
          r_cnt      <= '0;
          r_sd       <= 1'b1;
          r_sd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.sd       = r_sd;
  assign bus.sd_valid = r_sd_valid;
  assign bus.done     = r_done;

endmodule

// File: doc/shift_reg_piso_tx.md
Name: shift_reg_piso_tx

Overview:
Parallel-in/serial-out frame transmitter; counterpart of our parallel-load up/down register.
- Accepts an N-bit word over a load/ready handshake.
- Emits a serial frame on sd: start bit, N data bits, optional parity bit, stop bit. Bit order is selectable.
- Sits between register-file/counter datapaths and a serial link or the matching serial receiver.

Parameters:
N, 8, data word width (>=2)
CLK_DIV, 4, clk cycles per serial bit (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
syn_clr  in  1  synchronous abort; returns block to IDLE
load  in  1  word valid; accepted when load & ready at rising clk edge
d  in  N  parallel word, sampled on accept
msb_first  in  1  bit order, sampled on accept: 1 = MSB first, 0 = LSB first
ready  out  1  high only in IDLE
busy  out  1  high in any state other than IDLE
sd  out  1  serial data, registered; idle level 1
sd_valid  out  1  high while a data bit (not start/parity/stop) is on sd
done  out  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (rst=0, async):
  - State IDLE; sd=1, sd_valid=0, done=0, busy=0, ready=1.
  - Shift register, bit counter and divider counter cleared.
  - Reset mid-frame aborts immediately; no done pulse.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - On accept edge: capture d into the shift register and latch msb_first; go to START.
  - sd=0 is visible from the first cycle after the accept edge (latency 1).
- Each bit state holds for exactly CLK_DIV cycles, timed by a divider counter 0..CLK_DIV-1.
- DATA:
  - Transmits N bits; the bit counter runs 0..N-1.
  - LSB first: shift right, sd = sr[0]. MSB first: shift left, sd = sr[N-1].
  - sd_valid=1 for all N*CLK_DIV cycles.
- STOP: sd=1. done=1 on its final cycle, and the state returns to IDLE at that edge.
- Frame length: (N+2)*CLK_DIV cycles; (N+3)*CLK_DIV with parity.
- Back-to-back frames: load held high is accepted in the first IDLE cycle after done. Minimum gap is 1 idle cycle with sd=1.
- Load while busy: ignored; d is not sampled and the frame in flight is unaffected.
- syn_clr:
  - Highest priority after rst.
  - At the next edge: state IDLE, sd=1, sd_valid=0, no done pulse, counters cleared.
  - syn_clr together with load in IDLE: clear wins; the word is not accepted.
- d and msb_first changing mid-frame: no effect.
- Outputs sd, sd_valid and done are registered. ready and busy are decoded from the state register.

Optional Feature:
Macro: SHIFT_REG_PISO_TX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP.
  - sd = even parity (XOR of all N captured bits) for CLK_DIV cycles; sd_valid=0 during parity.
  - Frame length becomes (N+3)*CLK_DIV.
- Undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Test Plan:
1) Reset and idle: rst=0 for 2 cycles, then rst=1 and idle 3 cycles -> sd=1, ready=1, busy=0, done=0, sd_valid=0 throughout.
2) LSB-first frame (CLK_DIV=1, N=8, parity off): load 0xA8, msb_first=0 -> sd on cycles 1..10 = 0 | 0,0,0,1,0,1,0,1 | 1; sd_valid high on cycles 2..9; done on cycle 10; ready back at cycle 11.
3) MSB-first and divider: CLK_DIV=4, load 0xA8, msb_first=1 -> data bits 1,0,1,0,1,0,0,0, each held 4 cycles; frame is 40 cycles; load pulsed while busy with d=0x3C is ignored (frame bits unchanged).
4) Abort: start frame 0xA5, assert syn_clr during data bit 3 -> next edge sd=1, ready=1, no done pulse. A subsequent load 0x3C sends a correct complete frame.
5) Async reset mid-frame: drop rst during DATA -> outputs reach reset values without a clk edge. Also syn_clr and load in the same IDLE cycle -> no frame starts.
6) Parity (macro defined, CLK_DIV=1): load 0xA8 -> parity bit 1 on cycle 10, stop on cycle 11, done on cycle 11. Load 0x3C -> parity bit 0.
